// File: rtl/lzc_norm_pipe.sv
// rtl/lzc_norm_pipe.sv - elastic mantissa normaliser driven by an lzc count, one shift stage per count bit
// Optional count-consistency checker on out_err is enabled by defining NORM_CHECK_EN.
module lzc_norm_pipe #(
  parameter int XLEN = 64,
  parameter int XLOG = 6,
  parameter int EXPW = 11
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLOG-1:0] in_c,
  input  logic            in_v,
  input  logic [EXPW-1:0] in_e,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [EXPW-1:0] out_e,
  output logic            out_zero,
  output logic            out_uflow,
  output logic            out_err
);

  logic [XLOG-1:0] r_vld;
  logic [XLEN-1:0] r_a [XLOG];
  logic [EXPW-1:0] r_e [XLOG];
  logic [XLOG-1:0] r_c [XLOG];
  logic [XLOG-1:0] r_zero;
  logic [XLOG-1:0] r_uflow;

  logic [XLOG-1:0] w_rdy;
  logic [EXPW:0]   w_diff;
  logic            w_err0;
  logic [XLOG-1:0] w_vin;
  logic [XLEN-1:0] w_a [XLOG];
  logic [EXPW-1:0] w_e [XLOG];
  logic [XLOG-1:0] w_c [XLOG];
  logic [XLOG-1:0] w_zero;
  logic [XLOG-1:0] w_uflow;

  assign w_diff = {1'b0, in_e} - (EXPW+1)'(in_c);

  // ready_k = ~valid_k | ready_(k+1), unrolled: some stage at or after k is empty, or the sink takes
  always_comb begin
    w_rdy = '0;
    for (int k = 0; k < XLOG; k++) begin
      w_rdy[k] = out_ready | (((~r_vld) >> k) != '0);
    end
  end

  // Stage 0 also folds in the exponent subtract, zero handling and the first shift
  always_comb begin
    w_vin   = '0;
    w_zero  = '0;
    w_uflow = '0;
    for (int k = 0; k < XLOG; k++) begin
      w_a[k] = '0;
      w_e[k] = '0;
      w_c[k] = '0;
    end
    w_vin[0]   = in_valid;
    w_zero[0]  = ~in_v;
    w_uflow[0] = in_v & w_diff[EXPW];
    w_c[0]     = in_v ? in_c : '0;
    w_e[0]     = (in_v & ~w_diff[EXPW]) ? w_diff[EXPW-1:0] : '0;
    w_a[0]     = !in_v ? '0 : (in_c[0] ? (in_a << 1) : in_a);
    for (int k = 1; k < XLOG; k++) begin
      w_vin[k]   = r_vld[k-1];
      w_zero[k]  = r_zero[k-1];
      w_uflow[k] = r_uflow[k-1];
      w_c[k]     = r_c[k-1];
      w_e[k]     = r_e[k-1];
      w_a[k]     = r_c[k-1][k] ? (r_a[k-1] << (1 << k)) : r_a[k-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld   <= '0;
      r_zero  <= '0;
      r_uflow <= '0;
      for (int k = 0; k < XLOG; k++) begin
        r_a[k] <= '0;
        r_e[k] <= '0;
        r_c[k] <= '0;
      end
    end else begin
      for (int k = 0; k < XLOG; k++) begin
        if (w_rdy[k]) begin
          r_vld[k] <= w_vin[k];
          if (w_vin[k]) begin
            r_a[k]     <= w_a[k];
            r_e[k]     <= w_e[k];
            r_c[k]     <= w_c[k];
            r_zero[k]  <= w_zero[k];
            r_uflow[k] <= w_uflow[k];
          end
        end
      end
    end
  end

`ifdef NORM_CHECK_EN
  logic [XLOG-1:0] r_err;
  logic [XLOG-1:0] w_pos;
  logic [XLEN-1:0] w_top;

  // A correct count leaves exactly the value 1 once the bits below the leading one are shifted out
  assign w_pos  = XLOG'(XLEN-1) - in_c;
  assign w_top  = in_a >> w_pos;
  assign w_err0 = in_v & (w_top != XLEN'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_err <= '0;
    end else begin
      for (int k = 0; k < XLOG; k++) begin
        if (w_rdy[k] && w_vin[k]) begin
          r_err[k] <= (k == 0) ? w_err0 : r_err[(k == 0) ? 0 : k-1];
        end
      end
    end
  end

  assign out_err = r_err[XLOG-1];
`else
  assign w_err0  = 1'b0;
  assign out_err = w_err0;
`endif

  assign in_ready  = w_rdy[0];
  assign out_valid = r_vld[XLOG-1];
  assign out_a     = r_a[XLOG-1];
  assign out_e     = r_e[XLOG-1];
  assign out_zero  = r_zero[XLOG-1];
  assign out_uflow = r_uflow[XLOG-1];

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// tb/tb_lzc_norm_pipe.sv - scoreboard bench for lzc_norm_pipe (XLEN=64, XLOG=6, EXPW=11)
// Define NORM_CHECK_EN on both files to exercise out_err.
module tb_lzc_norm_pipe;

  localparam int XLEN = 64;
  localparam int XLOG = 6;
  localparam int EXPW = 11;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_a;
  logic [XLOG-1:0] in_c;
  logic            in_v;
  logic [EXPW-1:0] in_e;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_a;
  logic [EXPW-1:0] out_e;
  logic            out_zero;
  logic            out_uflow;
  logic            out_err;

  typedef struct {
    logic [XLEN-1:0] a;
    logic [EXPW-1:0] e;
    logic            z;
    logic            u;
    logic            r;
    int              acc;
    bit              lat;
  } exp_t;

  exp_t sb[$];
  exp_t h;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   lat_mode = 1'b0;
  int   idx;

  lzc_norm_pipe #(.XLEN(XLEN), .XLOG(XLOG), .EXPW(EXPW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_c      (in_c),
    .in_v      (in_v),
    .in_e      (in_e),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_e     (out_e),
    .out_zero  (out_zero),
    .out_uflow (out_uflow),
    .out_err   (out_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(logic [XLEN-1:0] a, logic [XLOG-1:0] c, logic v, logic [EXPW-1:0] e);
    exp_t r;
    int   d;
    r = '{default: '0};
    if (!v) begin
      r.z = 1'b1;
    end else begin
      r.a = a << c;
      d   = int'(e) - int'(c);
      if (d < 0) r.u = 1'b1;
      else       r.e = EXPW'(d);
`ifdef NORM_CHECK_EN
      r.r = (a[63 - int'(c)] != 1'b1);
      for (int j = 63; j > 63 - int'(c); j--) if (a[j]) r.r = 1'b1;
`endif
    end
    return r;
  endfunction

  // Outputs compared against the scoreboard head every cycle they are valid, so stalls check stability
  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("stray_beat", {63'd0, out_valid}, 64'd0);
        end else begin
          h = sb[0];
          check("out_a", out_a, h.a);
          check("out_e", 64'(out_e), 64'(h.e));
          check("out_zero", 64'(out_zero), 64'(h.z));
          check("out_uflow", 64'(out_uflow), 64'(h.u));
          check("out_err", 64'(out_err), 64'(h.r));
          if (out_ready) begin
            if (h.lat) check("latency", 64'(cyc - h.acc), 64'd6);
            void'(sb.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        h     = model(in_a, in_c, in_v, in_e);
        h.acc = cyc;
        h.lat = lat_mode;
        sb.push_back(h);
      end
    end
  end

  task automatic send(input logic [XLEN-1:0] a, input logic [XLOG-1:0] c, input logic v, input logic [EXPW-1:0] e);
    int n;
    in_valid = 1'b1;
    in_a = a; in_c = c; in_v = v; in_e = e;
    for (n = 0; n < 100; n++) begin
      @(negedge clock);
      if (in_ready) break;
      @(posedge clock); #1;
    end
    if (n == 100) check("send_timeout", 64'(n), 64'd0);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clock);
    check("drain", 64'(sb.size()), 64'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_c = '0; in_v = 1'b0; in_e = '0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_a", out_a, 64'd0);
    check("rst_out_e", 64'(out_e), 64'd0);
    check("rst_flags", {61'd0, out_zero, out_uflow, out_err}, 64'd0);
    @(posedge clock); #1;

    lat_mode = 1'b1;
    for (int i = 0; i < 64; i++) send(64'd1 << i, XLOG'(63 - i), 1'b1, 11'd100);
    drain();
    lat_mode = 1'b0;

    send(64'd0, 6'd5, 1'b0, 11'd50);
    send(64'd1, 6'd63, 1'b1, 11'd10);
    send(64'h8000_0000_1234_5678, 6'd0, 1'b1, 11'd77);
    send(64'h0000_0000_0000_0001, 6'd63, 1'b1, 11'd63);
    send(64'h00F0_0000_0000_0000, 6'd3, 1'b1, 11'd200);
    send(64'h00F0_0000_0000_0000, 6'd8, 1'b1, 11'd200);
    send(64'h0000_0001_F000_0000, 6'd31, 1'b1, 11'd2047);
    drain();

    out_ready = 1'b0;
    idx = 0;
    for (int t = 0; t < 80 && !(idx == 10 && sb.size() == 0); t++) begin
      in_valid = (idx < 10);
      in_a = 64'd1 << (idx * 5); in_c = XLOG'(63 - idx * 5); in_v = 1'b1; in_e = EXPW'(20 + idx);
      @(negedge clock);
      if (t == 6) begin
        check("bp_accepts", 64'(idx), 64'd6);
        check("bp_in_ready", 64'(in_ready), 64'd0);
      end
      if (in_valid && in_ready) idx++;
      @(posedge clock); #1;
      if (t == 12) out_ready = 1'b1;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", 64'(idx), 64'd10);
    drain();

    for (int i = 0; i < 4; i++) send(64'hFFFF_0000 << i, XLOG'(32 - i), 1'b1, 11'd500);
    reset = 1'b1;
    sb.delete();
    @(posedge clock);
    @(negedge clock);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    send(64'h0000_0000_0000_00FF, 6'd56, 1'b1, 11'd60);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
